// File: rtl/pcie_ctrl_pkg.sv
// pcie_ctrl_pkg: shared definitions for the PCIE transaction control slice.
// Contents: controller state encoding and the bit index of each FIFO inside
// the per-FIFO flag vectors, ordered {D1,D0,VC1,VC0,MF} = bits [4:0].
package pcie_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int IDX_MF  = 0;
  localparam int IDX_VC0 = 1;
  localparam int IDX_VC1 = 2;
  localparam int IDX_D0  = 3;
  localparam int IDX_D1  = 4;

endpackage

// File: rtl/pcie_vc_arbiter.sv
// pcie_vc_arbiter: picks which virtual-channel FIFO to pop into the D0/D1 demux.
// Latency: purely combinational, zero cycles.
// Backpressure: no pop while either destination FIFO is almost full.
// Ports:
//   i_en         pop permission from the controller (ACTIVE state only)
//   i_empty_vc0  VC0 empty flag
//   i_empty_vc1  VC1 empty flag
//   i_afull_d0   D0 almost-full flag
//   i_afull_d1   D1 almost-full flag
//   o_pop_vc0    pop VC0 this cycle
//   o_pop_vc1    pop VC1 this cycle (only when VC0 has nothing to give)
module pcie_vc_arbiter (
  input  logic i_en,
  input  logic i_empty_vc0,
  input  logic i_empty_vc1,
  input  logic i_afull_d0,
  input  logic i_afull_d1,
  output logic o_pop_vc0,
  output logic o_pop_vc1
);

  logic w_go;

  assign w_go = i_en & ~(i_afull_d0 | i_afull_d1);

  // Strict VC0 priority; the two pops are mutually exclusive by construction.
  assign o_pop_vc0 = w_go & ~i_empty_vc0;
  assign o_pop_vc1 = w_go &  i_empty_vc0 & ~i_empty_vc1;

endmodule

// File: rtl/pcie_trans_ctrl.sv
// pcie_trans_ctrl: sequencing for the PCIE transaction datapath (MF -> VC0/VC1 -> D0/D1).
// Latency: status, Pausa_MF, thresholds and error_src are registered (1 cycle);
//          pop_vc0/pop_vc1 are combinational from the current state and FIFO flags.
// Backpressure: Pausa_MF stalls the main FIFO when a VC FIFO is almost full
//          (always during INIT/ERROR); VC pops stop while D0 or D1 is almost full.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   init                  load thresholds / re-initialise
//   umbral_*              threshold inputs, captured into thr_* during INIT
//   fifo_empty/afull/error per-FIFO flag vectors {D1,D0,VC1,VC0,MF}
//   thr_*                 registered thresholds to the FIFOs
//   pop_vc0, pop_vc1      VC pop strobes
//   Pausa_MF              main-FIFO stall
//   active_out/idle_out/error_out  one-hot state status
//   error_src             fifo_error bits captured on ERROR entry
module pcie_trans_ctrl
  import pcie_ctrl_pkg::*;
#(
  parameter int UMB_MF_W = 2,
  parameter int UMB_VC_W = 4,
  parameter int UMB_D_W  = 2,
  parameter int NFIFO    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [UMB_MF_W-1:0] umbral_MF,
  input  logic [UMB_VC_W-1:0] umbral_VC0,
  input  logic [UMB_VC_W-1:0] umbral_VC1,
  input  logic [UMB_D_W-1:0]  umbral_D0,
  input  logic [UMB_D_W-1:0]  umbral_D1,
  input  logic [NFIFO-1:0]    fifo_empty,
  input  logic [NFIFO-1:0]    fifo_afull,
  input  logic [NFIFO-1:0]    fifo_error,
  output logic [UMB_MF_W-1:0] thr_MF,
  output logic [UMB_VC_W-1:0] thr_VC0,
  output logic [UMB_VC_W-1:0] thr_VC1,
  output logic [UMB_D_W-1:0]  thr_D0,
  output logic [UMB_D_W-1:0]  thr_D1,
  output logic                pop_vc0,
  output logic                pop_vc1,
  output logic                Pausa_MF,
  output logic                active_out,
  output logic                idle_out,
  output logic                error_out,
  output logic [NFIFO-1:0]    error_src
);

  state_t r_state;
  state_t w_next;

  logic w_err;
  logic w_all_empty;
  logic w_unused_afull_mf;

  assign w_err             = |fifo_error;
  assign w_all_empty       = &fifo_empty;
  // The main FIFO's own almost-full flag has no consumer here.
  assign w_unused_afull_mf = fifo_afull[IDX_MF];

  // Next-state logic; an error in any operating state beats init and traffic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:  w_next = ST_INIT;
      ST_INIT: begin
        if (w_err)      w_next = ST_ERROR;
        else if (!init) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_err)             w_next = ST_ERROR;
        else if (init)         w_next = ST_INIT;
        else if (!w_all_empty) w_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_err)            w_next = ST_ERROR;
        else if (init)        w_next = ST_INIT;
        else if (w_all_empty) w_next = ST_IDLE;
      end
      ST_ERROR: begin
        if (init) w_next = ST_INIT;
      end
      default:   w_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  // Status flags are decoded from the next state so they track r_state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_out <= 1'b0;
      idle_out   <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      active_out <= (w_next == ST_ACTIVE);
      idle_out   <= (w_next == ST_IDLE);
      error_out  <= (w_next == ST_ERROR);
    end
  end

  // Thresholds follow umbral_* while initialising and hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_MF  <= '0;
      thr_VC0 <= '0;
      thr_VC1 <= '0;
      thr_D0  <= '0;
      thr_D1  <= '0;
    end else if ((r_state == ST_INIT) && init) begin
      thr_MF  <= umbral_MF;
      thr_VC0 <= umbral_VC0;
      thr_VC1 <= umbral_VC1;
      thr_D0  <= umbral_D0;
      thr_D1  <= umbral_D1;
    end
  end

  // Capture only on the transition into ERROR so later errors cannot overwrite it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_src <= '0;
    end else if ((r_state != ST_ERROR) && (w_next == ST_ERROR)) begin
      error_src <= fifo_error;
    end else if ((r_state != ST_INIT) && (w_next == ST_INIT)) begin
      error_src <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Pausa_MF <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET:          Pausa_MF <= 1'b0;
        ST_INIT, ST_ERROR: Pausa_MF <= 1'b1;
        default:           Pausa_MF <= fifo_afull[IDX_VC0] | fifo_afull[IDX_VC1];
      endcase
    end
  end

  // Enable comes straight from r_state, so an async reset kills pops at once.
  pcie_vc_arbiter u_arb (
    .i_en        (r_state == ST_ACTIVE),
    .i_empty_vc0 (fifo_empty[IDX_VC0]),
    .i_empty_vc1 (fifo_empty[IDX_VC1]),
    .i_afull_d0  (fifo_afull[IDX_D0]),
    .i_afull_d1  (fifo_afull[IDX_D1]),
    .o_pop_vc0   (pop_vc0),
    .o_pop_vc1   (pop_vc1)
  );

endmodule

// File: tb/tb_pcie_trans_ctrl.sv
// tb_pcie_trans_ctrl: directed bench for pcie_trans_ctrl.
// Expected output vectors are queued when stimulus is applied and compared
// after the following edge (or after settling, for combinational pops).
module tb_pcie_trans_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [1:0] umbral_MF;
  logic [3:0] umbral_VC0;
  logic [3:0] umbral_VC1;
  logic [1:0] umbral_D0;
  logic [1:0] umbral_D1;
  logic [4:0] fifo_empty;
  logic [4:0] fifo_afull;
  logic [4:0] fifo_error;
  logic [1:0] thr_MF;
  logic [3:0] thr_VC0;
  logic [3:0] thr_VC1;
  logic [1:0] thr_D0;
  logic [1:0] thr_D1;
  logic       pop_vc0;
  logic       pop_vc1;
  logic       Pausa_MF;
  logic       active_out;
  logic       idle_out;
  logic       error_out;
  logic [4:0] error_src;

  int checks   = 0;
  int failures = 0;

  logic [14:0] exp_q[$];
  string       tag_q[$];
  logic [14:0] obs;

  assign obs = {active_out, idle_out, error_out, Pausa_MF, pop_vc0, pop_vc1, error_src, thr_VC0};

  always #5 clk = ~clk;

  pcie_trans_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .umbral_MF  (umbral_MF),
    .umbral_VC0 (umbral_VC0),
    .umbral_VC1 (umbral_VC1),
    .umbral_D0  (umbral_D0),
    .umbral_D1  (umbral_D1),
    .fifo_empty (fifo_empty),
    .fifo_afull (fifo_afull),
    .fifo_error (fifo_error),
    .thr_MF     (thr_MF),
    .thr_VC0    (thr_VC0),
    .thr_VC1    (thr_VC1),
    .thr_D0     (thr_D0),
    .thr_D1     (thr_D1),
    .pop_vc0    (pop_vc0),
    .pop_vc1    (pop_vc1),
    .Pausa_MF   (Pausa_MF),
    .active_out (active_out),
    .idle_out   (idle_out),
    .error_out  (error_out),
    .error_src  (error_src)
  );

  // {act, idle, err, pausa, pop0, pop1, error_src, thr_VC0}
  function automatic logic [14:0] mk(input logic a, input logic i, input logic e,
                                     input logic p, input logic p0, input logic p1,
                                     input logic [4:0] s, input logic [3:0] t);
    return {a, i, e, p, p0, p1, s, t};
  endfunction

  task automatic push(input string tag, input logic [14:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic chk();
    logic [14:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_underflow observed=%h", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  // Expectation for the state after the next rising edge.
  task automatic step(input string tag, input logic [14:0] v);
    push(tag, v);
    @(posedge clk);
    #1;
    chk();
  endtask

  // Expectation for combinational outputs with no clock edge.
  task automatic settle(input string tag, input logic [14:0] v);
    push(tag, v);
    #1;
    chk();
  endtask

  initial begin
    reset      = 1'b1;
    init       = 1'b0;
    umbral_MF  = 2'd0;
    umbral_VC0 = 4'h0;
    umbral_VC1 = 4'h0;
    umbral_D0  = 2'd0;
    umbral_D1  = 2'd0;
    fifo_empty = 5'b11111;
    fifo_afull = 5'b00000;
    fifo_error = 5'b00000;

    #2;
    settle("reset_state", mk(0,0,0,0,0,0,5'b00000,4'h0));

    @(negedge clk);
    reset      = 1'b0;
    init       = 1'b1;
    umbral_MF  = 2'd2;
    umbral_VC0 = 4'hA;
    umbral_VC1 = 4'h5;
    umbral_D0  = 2'd1;
    umbral_D1  = 2'd3;
    step("reset_to_init", mk(0,0,0,0,0,0,5'b00000,4'h0));
    step("init_load1",    mk(0,0,0,1,0,0,5'b00000,4'hA));
    step("init_load2",    mk(0,0,0,1,0,0,5'b00000,4'hA));

    @(negedge clk);
    init = 1'b0;
    step("init_to_idle", mk(0,1,0,1,0,0,5'b00000,4'hA));
    checks++;
    assert ({thr_MF, thr_VC1, thr_D0, thr_D1} === {2'd2, 4'h5, 2'd1, 2'd3}) else begin
      failures++;
      $error("FAIL thr_other observed=%h expected=%h",
             {thr_MF, thr_VC1, thr_D0, thr_D1}, {2'd2, 4'h5, 2'd1, 2'd3});
    end
    step("idle_hold", mk(0,1,0,0,0,0,5'b00000,4'hA));

    @(negedge clk);
    fifo_empty = 5'b11110;
    step("idle_to_active", mk(1,0,0,0,0,0,5'b00000,4'hA));

    @(negedge clk);
    fifo_empty = 5'b11111;
    step("active_to_idle", mk(0,1,0,0,0,0,5'b00000,4'hA));

    @(negedge clk);
    fifo_empty = 5'b11000;
    step("vc0_priority", mk(1,0,0,0,1,0,5'b00000,4'hA));

    @(negedge clk);
    fifo_empty = 5'b11010;
    settle("vc1_comb", mk(1,0,0,0,0,1,5'b00000,4'hA));
    step("vc1_edge",   mk(1,0,0,0,0,1,5'b00000,4'hA));

    @(negedge clk);
    fifo_afull = 5'b10000;
    settle("d1_afull_block", mk(1,0,0,0,0,0,5'b00000,4'hA));

    @(negedge clk);
    fifo_afull = 5'b00100;
    settle("vc1_afull_pop", mk(1,0,0,0,0,1,5'b00000,4'hA));
    step("pausa_vc1",       mk(1,0,0,1,0,1,5'b00000,4'hA));

    @(negedge clk);
    fifo_afull = 5'b00000;
    fifo_error = 5'b00100;
    step("error_entry", mk(0,0,1,0,0,0,5'b00100,4'hA));

    @(negedge clk);
    fifo_error = 5'b00010;
    step("error_sticky", mk(0,0,1,1,0,0,5'b00100,4'hA));

    @(negedge clk);
    fifo_error = 5'b00000;
    init       = 1'b1;
    umbral_VC0 = 4'h3;
    step("error_to_init", mk(0,0,0,1,0,0,5'b00000,4'hA));
    step("reinit_load",   mk(0,0,0,1,0,0,5'b00000,4'h3));

    @(negedge clk);
    init = 1'b0;
    step("reinit_idle",   mk(0,1,0,1,0,0,5'b00000,4'h3));
    step("reinit_active", mk(1,0,0,0,0,1,5'b00000,4'h3));

    @(negedge clk);
    init       = 1'b1;
    fifo_error = 5'b00001;
    step("error_beats_init", mk(0,0,1,0,0,0,5'b00001,4'h3));

    @(negedge clk);
    fifo_error = 5'b00000;
    step("error_to_init2", mk(0,0,0,1,0,0,5'b00000,4'h3));

    @(negedge clk);
    init = 1'b0;
    step("init_to_idle2",   mk(0,1,0,1,0,0,5'b00000,4'h3));
    step("idle_to_active2", mk(1,0,0,0,0,1,5'b00000,4'h3));

    @(negedge clk);
    fifo_empty = 5'b11000;
    settle("vc0_comb", mk(1,0,0,0,1,0,5'b00000,4'h3));

    #2;
    reset = 1'b1;
    settle("async_reset", mk(0,0,0,0,0,0,5'b00000,4'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
